// File: rtl/psram_bist.sv
// psram_bist: pattern write/read-back self-test sequencer for the PSRAM controller.
// Optional per-command latency counters are built when PSRAM_BIST_LATENCY_STATS_EN is defined.
module psram_bist #(
   parameter int ADDR_W        = 22,
   parameter int BYTES         = 1048576,
   parameter int WORD_MODE     = 0,
   parameter int TIMEOUT       = 64,
   parameter int STOP_ON_ERROR = 1
`ifdef PSRAM_BIST_LATENCY_STATS_EN
   ,
   parameter int WR_2X_THRESH  = 7,
   parameter int RD_2X_THRESH  = 13
`endif
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic [1:0]        pattern,
   output logic              read,
   output logic              write,
   output logic              byte_write,
   output logic [ADDR_W-1:0] addr,
   output logic [15:0]       din,
   input  logic [15:0]       dout,
   input  logic              busy,
   output logic              done,
   output logic              pass,
   output logic              timeout,
   output logic [15:0]       err_count,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [15:0]       fail_exp,
   output logic [15:0]       fail_got,
`ifdef PSRAM_BIST_LATENCY_STATS_EN
   output logic [23:0]       wr_1x,
   output logic [23:0]       wr_2x,
   output logic [23:0]       rd_1x,
   output logic [23:0]       rd_2x,
`endif
   output logic [2:0]        phase
);

   localparam int STEP = (WORD_MODE != 0) ? 2 : 1;
   localparam logic [ADDR_W-1:0] ASTEP = ADDR_W'(STEP);
   localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(BYTES - STEP);
   localparam logic [15:0]       TMO   = 16'(TIMEOUT);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WAIT_RDY = 3'd1,
      WR       = 3'd2,
      RD       = 3'd3,
      DONE     = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      S_PULSE = 2'd0,
      S_SKIP  = 2'd1,
      S_WAIT  = 2'd2
   } sub_t;

   state_t            state;
   sub_t              sub;
   logic [1:0]        pat;
   logic [ADDR_W-1:0] addr_nx;
   logic              is_last;
   logic [15:0]       cnt;

   logic [15:0]       got_d;
   logic [15:0]       exp_d;
   logic              mismatch;
   logic [15:0]       err_nx;
   logic              tmo_hit;

   function automatic logic [7:0] pbyte(input logic [1:0] p, input logic [23:0] a);
      logic [7:0] h;
      logic [7:0] r;
      h = a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hC3;
      case (p)
         2'd0:    r = h;
         2'd1:    r = a[7:0];
         2'd2:    r = 8'h01 << a[2:0];
         default: r = ~h;
      endcase
      return r;
   endfunction

   function automatic logic [15:0] wdata(input logic [1:0] p, input logic [ADDR_W-1:0] a);
      logic [23:0] a24;
      a24 = 24'(a);
      if (WORD_MODE != 0) return {pbyte(p, a24 | 24'd1), pbyte(p, a24)};
      return {2{pbyte(p, a24)}};
   endfunction

   assign byte_write = (WORD_MODE == 0);
   assign phase      = state;
   assign tmo_hit    = busy && (cnt + 16'd1 == TMO);

   // din still holds the expected data of the outstanding read
   always_comb begin
      if (WORD_MODE != 0) begin
         got_d = dout;
         exp_d = din;
      end else begin
         got_d = {8'h00, addr[0] ? dout[15:8] : dout[7:0]};
         exp_d = {8'h00, din[7:0]};
      end
      mismatch = (state == RD) && (got_d != exp_d);
      err_nx   = err_count;
      if (mismatch && err_count != 16'hFFFF) err_nx = err_count + 16'd1;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         sub       <= S_PULSE;
         pat       <= '0;
         addr      <= '0;
         addr_nx   <= '0;
         is_last   <= 1'b0;
         din       <= '0;
         read      <= 1'b0;
         write     <= 1'b0;
         cnt       <= '0;
         done      <= 1'b0;
         pass      <= 1'b0;
         timeout   <= 1'b0;
         err_count <= '0;
         fail_addr <= '0;
         fail_exp  <= '0;
         fail_got  <= '0;
`ifdef PSRAM_BIST_LATENCY_STATS_EN
         wr_1x     <= '0;
         wr_2x     <= '0;
         rd_1x     <= '0;
         rd_2x     <= '0;
`endif
      end else begin
         read  <= 1'b0;
         write <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state     <= WAIT_RDY;
                  done      <= 1'b0;
                  pass      <= 1'b0;
                  timeout   <= 1'b0;
                  err_count <= '0;
                  fail_addr <= '0;
                  fail_exp  <= '0;
                  fail_got  <= '0;
                  pat       <= pattern;
                  addr      <= '0;
                  cnt       <= '0;
`ifdef PSRAM_BIST_LATENCY_STATS_EN
                  wr_1x     <= '0;
                  wr_2x     <= '0;
                  rd_1x     <= '0;
                  rd_2x     <= '0;
`endif
               end
            end
            WAIT_RDY: begin
               if (!busy) begin
                  state <= WR;
                  sub   <= S_PULSE;
                  write <= 1'b1;
                  din   <= wdata(pat, '0);
                  cnt   <= '0;
               end else if (tmo_hit) begin
                  state   <= DONE;
                  done    <= 1'b1;
                  timeout <= 1'b1;
                  pass    <= 1'b0;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            WR, RD: begin
               case (sub)
                  S_PULSE: begin
                     // next address is prepared a cycle early to keep the adder off the command path
                     sub     <= S_SKIP;
                     cnt     <= 16'd1;
                     addr_nx <= addr + ASTEP;
                     is_last <= (addr == LAST);
                  end
                  S_SKIP: begin
                     sub <= S_WAIT;
                     cnt <= cnt + 16'd1;
                  end
                  S_WAIT: begin
                     if (busy) begin
                        if (tmo_hit) begin
                           state   <= DONE;
                           done    <= 1'b1;
                           timeout <= 1'b1;
                           pass    <= 1'b0;
                        end else begin
                           cnt <= cnt + 16'd1;
                        end
                     end else begin
                        cnt <= '0;
                        sub <= S_PULSE;
`ifdef PSRAM_BIST_LATENCY_STATS_EN
                        if (state == WR) begin
                           if (cnt > 16'(WR_2X_THRESH)) wr_2x <= wr_2x + 24'd1;
                           else wr_1x <= wr_1x + 24'd1;
                        end else begin
                           if (cnt > 16'(RD_2X_THRESH)) rd_2x <= rd_2x + 24'd1;
                           else rd_1x <= rd_1x + 24'd1;
                        end
`endif
                        err_count <= err_nx;
                        if (mismatch && err_count == 16'h0000) begin
                           fail_addr <= addr;
                           fail_exp  <= exp_d;
                           fail_got  <= got_d;
                        end
                        if (mismatch && STOP_ON_ERROR != 0) begin
                           state <= DONE;
                           done  <= 1'b1;
                           pass  <= 1'b0;
                        end else if (is_last && state == WR) begin
                           state <= RD;
                           addr  <= '0;
                           din   <= wdata(pat, '0);
                           read  <= 1'b1;
                        end else if (is_last) begin
                           state <= DONE;
                           done  <= 1'b1;
                           pass  <= (err_nx == 16'h0000) && !timeout;
                        end else begin
                           addr  <= addr_nx;
                           din   <= wdata(pat, addr_nx);
                           write <= (state == WR);
                           read  <= (state == RD);
                        end
                     end
                  end
                  default: sub <= S_PULSE;
               endcase
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_psram_bist.sv
// tb_psram_bist: three BIST instances (byte/stop, byte/count, word) against a PSRAM command model.
// Expected commands are queued per run and popped as the active instance issues them.
module tb_psram_bist;

   localparam int LAT = 6;

   typedef struct packed {
      logic        wr;
      logic [7:0]  a;
      logic [15:0] d;
   } cmd_t;

   logic        clk = 1'b0;
   logic        resetn = 1'b1;
   logic        start_v [3];
   logic [1:0]  pat_v [3];
   logic        read_v [3];
   logic        write_v [3];
   logic        bw_v [3];
   logic [7:0]  addr_v [3];
   logic [15:0] din_v [3];
   logic [15:0] dout_v [3];
   logic        busy_v [3];
   logic        done_v [3];
   logic        pass_v [3];
   logic        tmo_v [3];
   logic [15:0] err_v [3];
   logic [7:0]  fa_v [3];
   logic [15:0] fe_v [3];
   logic [15:0] fg_v [3];
   logic [2:0]  ph_v [3];
`ifdef PSRAM_BIST_LATENCY_STATS_EN
   logic [23:0] w1_v [3];
   logic [23:0] w2_v [3];
   logic [23:0] r1_v [3];
   logic [23:0] r2_v [3];
`endif

   logic [7:0]  mem [3][256];
   int          bcnt [3];
   logic        hold [3];
   logic        prd [3];
   logic [7:0]  pa [3];

   int          cur = 0;
   int          stuck_addr = -1;
   logic [255:0] corrupt_m = '0;
   int          cyc = 0;
   int          ncmd = 0;
   int          pulse_cyc = 0;
   int          nchk = 0;
   int          nerr = 0;
   cmd_t        exp_q [$];

   always #5 clk = ~clk;

   for (genvar i = 0; i < 3; i++) begin : g_dut
      psram_bist #(
         .ADDR_W(8),
         .BYTES(16),
         .WORD_MODE(i == 2 ? 1 : 0),
         .TIMEOUT(64),
         .STOP_ON_ERROR(i == 1 ? 0 : 1)
      ) u_dut (
         .clk(clk),
         .resetn(resetn),
         .start(start_v[i]),
         .pattern(pat_v[i]),
         .read(read_v[i]),
         .write(write_v[i]),
         .byte_write(bw_v[i]),
         .addr(addr_v[i]),
         .din(din_v[i]),
         .dout(dout_v[i]),
         .busy(busy_v[i]),
         .done(done_v[i]),
         .pass(pass_v[i]),
         .timeout(tmo_v[i]),
         .err_count(err_v[i]),
         .fail_addr(fa_v[i]),
         .fail_exp(fe_v[i]),
         .fail_got(fg_v[i]),
`ifdef PSRAM_BIST_LATENCY_STATS_EN
         .wr_1x(w1_v[i]),
         .wr_2x(w2_v[i]),
         .rd_1x(r1_v[i]),
         .rd_2x(r2_v[i]),
`endif
         .phase(ph_v[i])
      );
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      nchk++;
      if (got !== want) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   function automatic logic [7:0] pb(input int p, input int a);
      logic [23:0] x;
      logic [7:0] h;
      x = 24'(a);
      h = x[23:16] ^ x[15:8] ^ x[7:0] ^ 8'hC3;
      if (p == 0) return h;
      if (p == 1) return x[7:0];
      if (p == 2) return 8'(1 << (a % 8));
      return ~h;
   endfunction

   function automatic logic [15:0] edata(input int word, input int p, input int a);
      if (word != 0) return {pb(p, a + 1), pb(p, a)};
      return {pb(p, a), pb(p, a)};
   endfunction

   function automatic logic [15:0] rdata(input int i, input logic [7:0] a);
      logic [7:0] lo;
      logic [7:0] hi;
      lo = mem[i][{a[7:1], 1'b0}];
      hi = mem[i][{a[7:1], 1'b1}];
      if (i == cur && corrupt_m[a]) begin
         if (a[0]) hi = hi ^ 8'h01;
         else lo = lo ^ 8'h01;
      end
      return {hi, lo};
   endfunction

   // controller model: busy for LAT cycles after each pulse, read data on busy fall
   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (!resetn) begin
            busy_v[i] <= 1'b0;
            hold[i]   <= 1'b0;
            bcnt[i]   <= 0;
            prd[i]    <= 1'b0;
         end else begin
            if (write_v[i]) begin
               mem[i][addr_v[i]] <= din_v[i][7:0];
               if (i == 2) mem[i][{addr_v[i][7:1], 1'b1}] <= din_v[i][15:8];
            end
            if (write_v[i] || read_v[i]) begin
               busy_v[i] <= 1'b1;
               bcnt[i]   <= LAT;
               prd[i]    <= read_v[i];
               pa[i]     <= addr_v[i];
               if (write_v[i] && i == cur && int'(addr_v[i]) == stuck_addr) hold[i] <= 1'b1;
            end else if (hold[i]) begin
               if (stuck_addr < 0) hold[i] <= 1'b0;
            end else if (bcnt[i] > 1) begin
               bcnt[i] <= bcnt[i] - 1;
            end else if (busy_v[i]) begin
               busy_v[i] <= 1'b0;
               if (prd[i]) dout_v[i] <= rdata(i, pa[i]);
            end
         end
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      cmd_t e;
      if (write_v[cur] || read_v[cur]) begin
         ncmd++;
         pulse_cyc = cyc;
         if (exp_q.size() == 0) begin
            check("cmd_extra", {24'h0, addr_v[cur]}, 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            check("cmd_kind", {31'h0, write_v[cur]}, {31'h0, e.wr});
            check("cmd_addr", {24'h0, addr_v[cur]}, {24'h0, e.a});
            if (e.wr) check("cmd_din", {16'h0, din_v[cur]}, {16'h0, e.d});
            if (cur == 2 && write_v[cur] && addr_v[cur] == 8'd4)
               check("din_at4", {16'h0, din_v[cur]}, 32'h2010);
         end
      end
   end

   task automatic push_run(input int word, input int p, input int wr_last, input int rd_last);
      cmd_t c;
      int st;
      st = (word != 0) ? 2 : 1;
      for (int a = 0; a <= wr_last; a += st) begin
         c.wr = 1'b1;
         c.a  = 8'(a);
         c.d  = edata(word, p, a);
         exp_q.push_back(c);
      end
      for (int a = 0; a <= rd_last; a += st) begin
         c.wr = 1'b0;
         c.a  = 8'(a);
         c.d  = 16'h0;
         exp_q.push_back(c);
      end
   endtask

   task automatic kick(input int idx, input logic [1:0] p);
      @(negedge clk);
      pat_v[idx]   = p;
      start_v[idx] = 1'b1;
      @(negedge clk);
      start_v[idx] = 1'b0;
   endtask

   task automatic wait_done(input int idx, output int at);
      int n;
      n = 0;
      while (!done_v[idx] && n < 3000) begin
         @(negedge clk);
         n++;
      end
      at = cyc;
      check("done_seen", {31'h0, done_v[idx]}, 32'h1);
   endtask

   initial begin
      int t;
      int n;
      for (int i = 0; i < 3; i++) begin
         start_v[i] = 1'b0;
         pat_v[i]   = 2'd0;
      end
      #1 resetn = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_read", {31'h0, read_v[0]}, 32'h0);
      check("rst_write", {31'h0, write_v[0]}, 32'h0);
      check("rst_addr", {24'h0, addr_v[0]}, 32'h0);
      check("rst_done", {31'h0, done_v[0]}, 32'h0);
      check("rst_pass", {31'h0, pass_v[0]}, 32'h0);
      check("rst_phase", {29'h0, ph_v[0]}, 32'h0);
      check("bw_byte", {31'h0, bw_v[0]}, 32'h1);
      check("bw_word", {31'h0, bw_v[2]}, 32'h0);
      resetn = 1'b1;

      // 1: byte mode hash, full pass
      cur = 0;
      ncmd = 0;
      push_run(0, 0, 15, 15);
      kick(0, 2'd0);
      wait_done(0, t);
      check("t1_ncmd", ncmd, 32);
      check("t1_pass", {31'h0, pass_v[0]}, 32'h1);
      check("t1_err", {16'h0, err_v[0]}, 32'h0);
      check("t1_phase", {29'h0, ph_v[0]}, 32'h4);
      check("t1_q", exp_q.size(), 0);

      // 2: word mode walking one
      cur = 2;
      ncmd = 0;
      push_run(1, 2, 15, 15);
      kick(2, 2'd2);
      wait_done(2, t);
      check("t2_ncmd", ncmd, 16);
      check("t2_pass", {31'h0, pass_v[2]}, 32'h1);
      check("t2_q", exp_q.size(), 0);

      // 3: stop on first error at address 5
      cur = 0;
      corrupt_m = '0;
      corrupt_m[5] = 1'b1;
      push_run(0, 0, 15, 5);
      kick(0, 2'd0);
      wait_done(0, t);
      check("t3_err", {16'h0, err_v[0]}, 32'h1);
      check("t3_faddr", {24'h0, fa_v[0]}, 32'h5);
      check("t3_fexp", {24'h0, fe_v[0][7:0]}, 32'hC6);
      check("t3_fgot", {24'h0, fg_v[0][7:0]}, 32'hC7);
      check("t3_pass", {31'h0, pass_v[0]}, 32'h0);
      check("t3_q", exp_q.size(), 0);

      // 4: count mode, errors at 5 and 9
      cur = 1;
      corrupt_m[9] = 1'b1;
      push_run(0, 0, 15, 15);
      kick(1, 2'd0);
      wait_done(1, t);
      check("t4_err", {16'h0, err_v[1]}, 32'h2);
      check("t4_faddr", {24'h0, fa_v[1]}, 32'h5);
      check("t4_pass", {31'h0, pass_v[1]}, 32'h0);
      check("t4_q", exp_q.size(), 0);
      corrupt_m = '0;

      // 5: busy stuck after the third write
      cur = 0;
      stuck_addr = 2;
      push_run(0, 0, 2, -1);
      kick(0, 2'd0);
      wait_done(0, t);
      check("t5_lat", t - pulse_cyc, 64);
      check("t5_tmo", {31'h0, tmo_v[0]}, 32'h1);
      check("t5_pass", {31'h0, pass_v[0]}, 32'h0);
      check("t5_q", exp_q.size(), 0);
      stuck_addr = -1;
      repeat (12) @(negedge clk);

      // 6: reset during a read wait, then a clean run
      push_run(0, 3, 15, 15);
      kick(0, 2'd3);
      n = 0;
      while (!(ph_v[0] == 3'd3 && busy_v[0]) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("t6_in_rd", {29'h0, ph_v[0]}, 32'h3);
      resetn = 1'b0;
      #1;
      check("t6_read", {31'h0, read_v[0]}, 32'h0);
      check("t6_addr", {24'h0, addr_v[0]}, 32'h0);
      check("t6_din", {16'h0, din_v[0]}, 32'h0);
      check("t6_phase", {29'h0, ph_v[0]}, 32'h0);
      check("t6_err", {16'h0, err_v[0]}, 32'h0);
      check("t6_tmo", {31'h0, tmo_v[0]}, 32'h0);
      exp_q.delete();
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      repeat (3) @(negedge clk);
      push_run(0, 3, 15, 15);
      kick(0, 2'd3);
      wait_done(0, t);
      check("t6_pass", {31'h0, pass_v[0]}, 32'h1);
      check("t6_q", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule

// File: doc/psram_bist.md
# psram_bist

Parametrised built-in self-test engine for the PSRAM controller. It replaces the hard-wired write-then-read test sequencer with a reusable block that has these features:
- selectable data patterns
- byte or 16-bit word access
- configurable region size
- stop-on-error or error-count mode
- busy timeouts
- a captured first-failure record

It sits between the board top (buttons, LEDs, UART printer) and the controller's `read`/`write`/`busy` command interface, on the controller's clock.

## Interface
- `ADDR_W`, 22: controller byte-address width.
- `BYTES`, 1048576: test region size in bytes, starting at address 0. Must be a power of two, at least 2, and at most 2^ADDR_W.
- `WORD_MODE`, 0: 0 = byte writes with a byte compare; 1 = 16-bit writes with a 16-bit compare, address step 2.
- `TIMEOUT`, 64: maximum cycles `busy` may stay high per command before the test aborts.
- `STOP_ON_ERROR`, 1: 1 = abort on the first mismatch; 0 = count mismatches and finish the pass.
- `clk`  in  1  controller clock. All logic is on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  level. Sampled in IDLE and DONE; starts a run.
- `pattern`  in  2  0 = hash, 1 = address byte, 2 = walking one, 3 = inverted hash. Latched at start.
- `read`, `write`  out  1  one-cycle command pulses to the controller.
- `byte_write`  out  1  equals `!WORD_MODE`, constant.
- `addr`  out  ADDR_W  command address.
- `din`  out  16  write data.
- `dout`  in  16  read data, valid in the cycle `busy` is first seen low after a read.
- `busy`  in  1  controller busy.
- `done`  out  1  high in DONE.
- `pass`  out  1  high in DONE when there was no mismatch and no timeout.
- `timeout`  out  1  sticky; set when an abort was caused by `busy`.
- `err_count`  out  16  mismatch count, saturating at 16'hFFFF.
- `fail_addr`  out  ADDR_W  address of the first mismatch.
- `fail_exp`, `fail_got`  out  16  expected and read data for the first mismatch.
- `phase`  out  3  current state encoding, for the LEDs and UART.

## Operation
Pattern byte `p(a)`, with `a` zero-extended to 24 bits:
- hash: `a[7:0]^a[15:8]^a[23:16]^8'hC3`
- address byte: `a[7:0]`
- walking one: `8'h01<<a[2:0]`
- inverted hash: `~hash`

Expected data:
- Byte mode: `din = {p(a),p(a)}`; the compare uses `dout[15:8]` when `a[0]=1`, else `dout[7:0]`. The other byte is ignored.
- Word mode: `din = {p(a+1),p(a)}` with `a` even; the compare is the full 16 bits.

State machine (`phase` encoding in brackets):
- IDLE (0): on `start`, clear `err_count`, `fail_*`, `timeout` and `pass`, latch `pattern`, set `addr=0`, go to WAIT_RDY.
- WAIT_RDY (1): when `busy=0`, go to WR.
- WR (2): pulse `write` for one cycle, then skip one cycle. Then wait for `busy=0` and advance `addr` by the step. The last address (`BYTES-step`) goes to RD with `addr=0`.
- RD (3): pulse `read` and skip one cycle. Then wait for `busy=0` and compare. On a mismatch:
  - increment `err_count` (saturating);
  - on the first error, capture `fail_addr`, `fail_exp` and `fail_got`;
  - if `STOP_ON_ERROR=1`, go to DONE.
  Otherwise advance `addr`; the last address goes to DONE.
- DONE (4): `done=1`; `pass = (err_count==0) && !timeout`. `start` restarts the run exactly as from IDLE.
- A single cycle counter counts from the command pulse. If it reaches `TIMEOUT` in WAIT_RDY, WR or RD, set `timeout`, clear `pass` and go to DONE.
- WAIT_RDY uses the same counter, counting from state entry.

## Timing
- Reset value of every output: 0 (`phase` = IDLE). `byte_write` is constant at `!WORD_MODE`.
- `addr` and `din` are registered. They are valid in the `read`/`write` pulse cycle and stay held until the next command.
- Minimum command period is 3 cycles: pulse, skip, then `busy` low.
- A full run takes `2*BYTES/step` commands.
- The compare result is registered, so `err_count` updates one cycle after `busy` falls.
- The DONE transition follows the final compare.
- The address increment must close timing at 100 MHz. Pipelining is permitted as long as it does not stretch the command period.
- `resetn` asserted mid-command returns the block to IDLE immediately. No further pulses are issued.
- `start` held high in DONE restarts the run every time a run completes. This is intended for soak testing.

## Configuration
- `PSRAM_BIST_LATENCY_STATS_EN`
  - Defined: four 24-bit output counters `wr_1x`, `wr_2x`, `rd_1x` and `rd_2x` are added.
  - A command is counted as 2x when its busy duration, from pulse to `busy` low, exceeds `WR_2X_THRESH` or `RD_2X_THRESH`. Both thresholds are parameters, with defaults 7 and 13.
  - The counters are cleared on start.
  - Undefined: the ports and logic are absent.

## Test plan
1. Ideal controller model (busy for 6 cycles), `BYTES=16`, `pattern=0`, byte mode → 32 commands, then `done=1`, `pass=1`, `err_count=0`.
2. `WORD_MODE=1`, `BYTES=16`, `pattern=2` → 8 writes. At `addr=4`, `din` is 16'h2010. The run ends with `pass=1`.
3. Model corrupts the read at address 5 (`^8'h01`), `STOP_ON_ERROR=1`, hash → DONE with `err_count=1`, `fail_addr=5`, `fail_exp[7:0]=8'hC6`, `fail_got[7:0]=8'hC7`.
4. Same corruption at addresses 5 and 9, `STOP_ON_ERROR=0` → all 16 reads done, `err_count=2`, `fail_addr=5`, `pass=0`.
5. `busy` stuck high after the 3rd write, `TIMEOUT=64` → DONE 64 cycles after the pulse, `timeout=1`, `pass=0`.
6. Pulse `resetn` low during the RD wait → all outputs 0 and `phase=0` immediately. Then a `start` completes normally with `pass=1`.
